jtcop_colmix: RTL and testbench

- Colour mixer directly downstream of the three BAC06 tilemap layers and the sprite engine.
- Takes one 8-bit pixel per layer on each pxl_cen and resolves layer priority under CPU control.
- Looks the winning pixel up in an internal palette RAM and drives blanked 4-bit-per-channel RGB plus delayed blanking signals to the video output.

---
 rtl/jtcop_colmix.sv | 103 ++++++++++
 tb/tb_jtcop_colmix.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/jtcop_colmix.sv
// jtcop_colmix: BAC06/sprite layer priority mixer with palette RAM and blanked RGB output.
// Define JTCOP_LAYER_MASK_EN to add the gfx_en layer mask input.
`timescale 1ns/1ps
module jtcop_colmix #(
  parameter int PAL_AW    = 10,
  parameter int BLANK_DLY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        LVBL,
  input  logic [7:0]  bg0_pxl,
  input  logic [7:0]  bg1_pxl,
  input  logic [7:0]  bg2_pxl,
  input  logic [7:0]  obj_pxl,
`ifdef JTCOP_LAYER_MASK_EN
  input  logic [3:0]  gfx_en,
`endif
  input  logic        pal_cs,
  input  logic        pri_cs,
  input  logic [9:0]  cpu_addr,
  input  logic [15:0] cpu_dout,
  input  logic [1:0]  cpu_dsn,
  input  logic        cpu_rnw,
  output logic [15:0] cpu_din,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);
  logic [15:0]          pal_q [0:2**PAL_AW-1];
  logic [1:0]           pri_q;
  logic [7:0]           pxl_q [4];
  logic [9:0]           addr_q, addr_d;
  logic                 none_q, none_d;
  logic [BLANK_DLY-1:0] lh_q, lv_q;
  logic [11:0]          rgb_q;
  logic [15:0]          din_q;
  logic [3:0]           en, op;
  logic [1:0]           sel;
  logic                 pal_wr;
`ifdef JTCOP_LAYER_MASK_EN
  assign en = {gfx_en[2], gfx_en[1], gfx_en[3], gfx_en[0]};
`else
  assign en = 4'hf;
`endif
  assign pal_wr = pal_cs & ~cpu_rnw;
  // Layers are indexed by their palette bank: 0 bg0, 1 obj, 2 bg1, 3 bg2
  always_comb begin
    op[0]  = en[0] & (pri_q != 2'd2 || pxl_q[0][3:0] != 4'd0);
    op[1]  = en[1] & (pxl_q[1][3:0] != 4'd0);
    op[2]  = en[2] & (pri_q == 2'd2 || pxl_q[2][3:0] != 4'd0);
    op[3]  = en[3] & (pxl_q[3][3:0] != 4'd0);
    sel    = pri_q == 2'd3 ? (op[1] ? 2'd1 : op[3] ? 2'd3 : op[2] ? 2'd2 : 2'd0) :
             op[3]         ? 2'd3 :
             pri_q == 2'd0 ? (op[2] ? 2'd2 : op[1] ? 2'd1 : 2'd0) :
             pri_q == 2'd1 ? (op[1] ? 2'd1 : op[2] ? 2'd2 : 2'd0) :
                             (op[1] ? 2'd1 : op[0] ? 2'd0 : 2'd2);
    addr_d = {sel, pxl_q[sel]};
    none_d = ~|op;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q  <= 2'd0;
      pxl_q  <= '{default: 8'd0};
      addr_q <= 10'd0;
      none_q <= 1'b0;
      lh_q   <= '0;
      lv_q   <= '0;
    end else begin
      if (pri_cs && !cpu_rnw && !cpu_dsn[0]) pri_q <= cpu_dout[1:0];
      if (pxl_cen) begin
        pxl_q  <= '{bg0_pxl, obj_pxl, bg1_pxl, bg2_pxl};
        addr_q <= addr_d;
        none_q <= none_d;
        lh_q   <= {lh_q[BLANK_DLY-2:0], LHBL};
        lv_q   <= {lv_q[BLANK_DLY-2:0], LVBL};
      end
    end
  end
  // Reads see the pre-write word, so a same-cycle CPU write never reaches the video read
  always_ff @(posedge clk) begin
    if (pal_wr && !cpu_dsn[0]) pal_q[cpu_addr[PAL_AW-1:0]][7:0] <= cpu_dout[7:0];
    if (pal_wr && !cpu_dsn[1]) pal_q[cpu_addr[PAL_AW-1:0]][15:8] <= cpu_dout[15:8];
    if (rst) begin
      rgb_q <= 12'd0;
      din_q <= 16'd0;
    end else begin
      if (pxl_cen)
        rgb_q <= (lh_q[BLANK_DLY-2] && lv_q[BLANK_DLY-2] && !none_q) ? pal_q[addr_q[PAL_AW-1:0]][11:0] : 12'd0;
      if (pal_cs && cpu_rnw) din_q <= pal_q[cpu_addr[PAL_AW-1:0]];
      else if (pri_cs && cpu_rnw) din_q <= {14'd0, pri_q};
    end
  end
  assign red      = rgb_q[3:0];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[11:8];
  assign cpu_din  = din_q;
  assign LHBL_dly = lh_q[BLANK_DLY-1];
  assign LVBL_dly = lv_q[BLANK_DLY-1];
endmodule

// File: tb/tb_jtcop_colmix.sv
// tb_jtcop_colmix: table vectors, hand sequences and randomized streams against a palette/priority model.
`timescale 1ns/1ps
module tb_jtcop_colmix;
  logic        clk = 0, rst = 1, pxl_cen = 0, LHBL = 1, LVBL = 1;
  logic [7:0]  bg0_pxl = 0, bg1_pxl = 0, bg2_pxl = 0, obj_pxl = 0;
  logic        pal_cs = 0, pri_cs = 0, cpu_rnw = 1;
  logic [9:0]  cpu_addr = 0;
  logic [15:0] cpu_dout = 0, cpu_din;
  logic [1:0]  cpu_dsn = 2'b11;
  logic [3:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;
  int          checks = 0, errors = 0;
  logic [15:0] pal_m [1024];
  logic [1:0]  pri_m;
  typedef struct {
    logic [1:0] pri;
    logic [7:0] b0, ob, b1, b2;
    logic       lh, lv;
    logic [9:0] addr;
  } vec_t;
  vec_t vecs [14];
  logic [13:0] hist [$];

  jtcop_colmix dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .bg0_pxl(bg0_pxl), .bg1_pxl(bg1_pxl), .bg2_pxl(bg2_pxl), .obj_pxl(obj_pxl),
    .pal_cs(pal_cs), .pri_cs(pri_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_dsn(cpu_dsn), .cpu_rnw(cpu_rnw), .cpu_din(cpu_din),
    .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Layers listed bottom to top per priority mode; entry 0 is the backdrop, last opaque one wins
  function automatic logic [9:0] ref_addr(input logic [1:0] p, input logic [7:0] b0, ob, b1, b2);
    logic [7:0] px [4];
    int ord [4][4];
    int w;
    px  = '{b0, ob, b1, b2};
    ord = '{'{0, 1, 2, 3}, '{0, 2, 1, 3}, '{2, 0, 1, 3}, '{0, 2, 3, 1}};
    w   = ord[p][0];
    for (int j = 1; j < 4; j++) if (px[ord[p][j]][3:0] != 4'd0) w = ord[p][j];
    return {w[1:0], px[w]};
  endfunction

  function automatic logic [13:0] ref_out(input logic lh, lv, input logic [9:0] a);
    return {lh, lv, (lh && lv) ? pal_m[a][11:0] : 12'd0};
  endfunction

  function automatic logic [7:0] rnd_pxl();
    logic [7:0] v;
    v[7:4] = 4'($urandom_range(0, 15));
    v[3:0] = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    pxl_cen = 0; pal_cs = 0; pri_cs = 0; cpu_rnw = 1; cpu_dsn = 2'b11;
  endtask

  task automatic pal_wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] dsn);
    pal_cs = 1; cpu_rnw = 0; cpu_addr = a; cpu_dout = d; cpu_dsn = dsn;
    cyc();
    if (!dsn[0]) pal_m[a][7:0] = d[7:0];
    if (!dsn[1]) pal_m[a][15:8] = d[15:8];
  endtask

  task automatic pal_rd(input logic [9:0] a, input string name);
    pal_cs = 1; cpu_rnw = 1; cpu_addr = a;
    cyc();
    check(name, cpu_din, pal_m[a]);
  endtask

  task automatic pri_wr(input logic [1:0] p);
    pri_cs = 1; cpu_rnw = 0; cpu_dout = {14'd0, p}; cpu_dsn = 2'b00;
    cyc();
    pri_m = p;
  endtask

  task automatic set_pix(input logic [7:0] b0, ob, b1, b2, input logic lh, lv);
    bg0_pxl = b0; obj_pxl = ob; bg1_pxl = b1; bg2_pxl = b2; LHBL = lh; LVBL = lv; pxl_cen = 1;
  endtask

  task automatic pix(input logic [7:0] b0, ob, b1, b2, input logic lh, lv);
    set_pix(b0, ob, b1, b2, lh, lv);
    cyc();
  endtask

  function automatic logic [13:0] dut_out();
    return {LHBL_dly, LVBL_dly, blue, green, red};
  endfunction

  initial begin
    logic [15:0] old;
    logic        lhs [7];
    vecs[0]  = '{2'd0, 8'h15, 8'h27, 8'h30, 8'h40, 1'b1, 1'b1, 10'h127};
    vecs[1]  = '{2'd3, 8'h15, 8'h27, 8'h30, 8'h41, 1'b1, 1'b1, 10'h127};
    vecs[2]  = '{2'd1, 8'h15, 8'h27, 8'h30, 8'h41, 1'b1, 1'b1, 10'h341};
    vecs[3]  = '{2'd0, 8'h15, 8'h20, 8'h30, 8'h40, 1'b1, 1'b1, 10'h015};
    vecs[4]  = '{2'd0, 8'h00, 8'h20, 8'h30, 8'h40, 1'b1, 1'b1, 10'h000};
    vecs[5]  = '{2'd1, 8'h15, 8'h27, 8'h3A, 8'h40, 1'b1, 1'b1, 10'h127};
    vecs[6]  = '{2'd0, 8'h15, 8'h27, 8'h3A, 8'h40, 1'b1, 1'b1, 10'h23A};
    vecs[7]  = '{2'd2, 8'h15, 8'h20, 8'h3A, 8'h40, 1'b1, 1'b1, 10'h015};
    vecs[8]  = '{2'd2, 8'h10, 8'h20, 8'h3A, 8'h40, 1'b1, 1'b1, 10'h23A};
    vecs[9]  = '{2'd2, 8'h10, 8'h20, 8'h30, 8'h40, 1'b1, 1'b1, 10'h230};
    vecs[10] = '{2'd2, 8'h15, 8'h27, 8'h3A, 8'h40, 1'b1, 1'b1, 10'h127};
    vecs[11] = '{2'd3, 8'h15, 8'h20, 8'h3A, 8'h41, 1'b1, 1'b1, 10'h341};
    vecs[12] = '{2'd0, 8'h15, 8'h27, 8'h30, 8'h40, 1'b0, 1'b1, 10'h127};
    vecs[13] = '{2'd1, 8'h15, 8'h27, 8'h30, 8'h40, 1'b1, 1'b0, 10'h127};
    // reset with pxl_cen active
    rst = 1; pxl_cen = 1;
    @(posedge clk); #1 pxl_cen = 0;
    @(posedge clk); #1 rst = 0;
    check("reset_out", dut_out(), 14'd0);
    check("reset_din", cpu_din, 16'd0);
    cyc(); cyc();
    check("idle_out", dut_out(), 14'd0);
    pri_cs = 1; cpu_rnw = 1;
    cyc();
    check("pri_reset_rd", cpu_din, 16'd0);
    // palette fill with distinct words
    for (int a = 0; a < 1024; a++) pal_wr(10'(a), 16'((a * 37 + 5) & 16'h0FFF), 2'b00);
    pal_rd(10'h000, "pal_rd0");
    pal_rd(10'h3FF, "pal_rd3ff");
    pal_wr(10'h123, 16'h0ABC, 2'b00);
    pal_wr(10'h123, 16'h00FF, 2'b10);
    pal_rd(10'h123, "byte_wr");
    check("byte_wr_val", cpu_din, 16'h0AFF);
    cyc(); cyc();
    check("din_hold", cpu_din, 16'h0AFF);
    pri_wr(2'd2);
    pri_cs = 1; cpu_rnw = 1;
    cyc();
    check("pri_rd", cpu_din, 16'h0002);
    // table vectors: pixels held for 3 ticks so the output reflects only this vector
    foreach (vecs[i]) begin
      pri_wr(vecs[i].pri);
      repeat (3) pix(vecs[i].b0, vecs[i].ob, vecs[i].b1, vecs[i].b2, vecs[i].lh, vecs[i].lv);
      check($sformatf("vec%0d_ref", i), ref_addr(vecs[i].pri, vecs[i].b0, vecs[i].ob, vecs[i].b1, vecs[i].b2), vecs[i].addr);
      check($sformatf("vec%0d_out", i), dut_out(), ref_out(vecs[i].lh, vecs[i].lv, vecs[i].addr));
    end
    // one-pixel horizontal blank
    pri_wr(2'd0);
    lhs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      pix(8'h15, 8'h27, 8'h30, 8'h40, lhs[i], 1'b1);
      if (i >= 2) check($sformatf("blank%0d", i), dut_out(), ref_out(lhs[i-2], 1'b1, 10'h127));
    end
    // CPU write colliding with the video read of the same word
    pix(8'h15, 8'h20, 8'h30, 8'h40, 1, 1);
    pix(8'h15, 8'h20, 8'h30, 8'h40, 1, 1);
    old = pal_m[10'h015];
    set_pix(8'h15, 8'h20, 8'h30, 8'h40, 1, 1);
    pal_wr(10'h015, 16'h0FFF, 2'b00);
    check("collide_old", dut_out(), {2'b11, old[11:0]});
    pix(8'h15, 8'h20, 8'h30, 8'h40, 1, 1);
    check("collide_new", dut_out(), {2'b11, 12'hFFF});
    // randomized streams, one priority mode per block, with idle gaps and CPU reads
    for (int blk = 0; blk < 4; blk++) begin
      pri_wr(2'(blk));
      hist.delete();
      for (int i = 0; i < 40; i++) begin
        logic [7:0] b0, ob, b1, b2;
        logic lh, lv;
        b0 = rnd_pxl(); ob = rnd_pxl(); b1 = rnd_pxl(); b2 = rnd_pxl();
        lh = ($urandom_range(0, 7) != 0);
        lv = ($urandom_range(0, 7) != 0);
        pix(b0, ob, b1, b2, lh, lv);
        hist.push_back(ref_out(lh, lv, ref_addr(pri_m, b0, ob, b1, b2)));
        if (hist.size() == 3) check($sformatf("rnd%0d_%0d", blk, i), dut_out(), hist.pop_front());
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 3) == 0) pal_rd(10'($urandom_range(0, 1023)), "rnd_rd");
          else cyc();
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
